piso_shift_reg: RTL and testbench

PISO_SHIFT_REG -- requirements
Module: piso_shift_reg

---
 rtl/piso_shift_reg.sv | 71 +++++++
 tb/tb_piso_shift_reg.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/piso_shift_reg.sv
// Parallel-in / serial-out shift register with valid/ready load handshake and hold stall.
// Bit order: define PISO_MSB_FIRST_EN for MSB-first; default build sends LSB first.
module piso_shift_reg #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_valid,
    input  logic [WIDTH-1:0] load_data,
    output logic             load_ready,
    input  logic             hold,
    output logic             sout,
    output logic             sout_valid,
    output logic             done
);

    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] shreg;
    logic [CNT_W-1:0] cnt;
    logic             last_bit;
    logic             accept;
    logic             out_bit;

`ifdef PISO_MSB_FIRST_EN
    function automatic logic [WIDTH-1:0] shift_one(input logic [WIDTH-1:0] x);
        return {x[WIDTH-2:0], 1'b0};
    endfunction
    assign out_bit = shreg[WIDTH-1];
`else
    function automatic logic [WIDTH-1:0] shift_one(input logic [WIDTH-1:0] x);
        return {1'b0, x[WIDTH-1:1]};
    endfunction
    assign out_bit = shreg[0];
`endif

    // The final bit of a word frees the register unless the line is stalled.
    assign last_bit   = (state == SHIFT) && (cnt == LAST_CNT) && !hold;
    assign load_ready = !rst && ((state == IDLE) || last_bit);
    assign accept     = load_valid && load_ready;
    assign done       = last_bit;
    assign sout_valid = (state == SHIFT);
    assign sout       = (state == SHIFT) ? out_bit : 1'b1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            shreg <= '0;
            cnt   <= '0;
        end else if (accept) begin
            state <= SHIFT;
            shreg <= load_data;
            cnt   <= '0;
        end else if ((state == SHIFT) && !hold) begin
            if (cnt == LAST_CNT) begin
                state <= IDLE;
            end else begin
                shreg <= shift_one(shreg);
                cnt   <= cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_piso_shift_reg.sv
// Self-checking bench for piso_shift_reg: directed scenarios plus random traffic
// checked against a queue-of-bits reference model.
module tb_piso_shift_reg;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic         load_valid;
    logic [W-1:0] load_data;
    logic         load_ready;
    logic         hold;
    logic         sout;
    logic         sout_valid;
    logic         done;

    int checks = 0;
    int errors = 0;
    int n_valid = 0;
    int n_done = 0;
    logic q[$];
    logic cap[$];

    piso_shift_reg #(.WIDTH(W)) dut (
        .clk        (clk),
        .rst        (rst),
        .load_valid (load_valid),
        .load_data  (load_data),
        .load_ready (load_ready),
        .hold       (hold),
        .sout       (sout),
        .sout_valid (sout_valid),
        .done       (done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic chk_int(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic logic exp_ready(input logic h);
        return (q.size() == 0) || (q.size() == 1 && !h);
    endfunction

    // Rebuild a word from captured serial bits starting at index base.
    function automatic int word_at(input int base);
        logic [W-1:0] v;
        v = '0;
        for (int i = 0; i < W; i++) begin
`ifdef PISO_MSB_FIRST_EN
            v[W-1-i] = cap[base+i];
`else
            v[i] = cap[base+i];
`endif
        end
        return int'(v);
    endfunction

    task automatic clr_stats();
        n_valid = 0;
        n_done  = 0;
        cap.delete();
    endtask

    task automatic cycle(input logic lv, input logic [W-1:0] ld, input logic h);
        logic exp_act;
        load_valid = lv;
        load_data  = ld;
        hold       = h;
        @(negedge clk);
        exp_act = (q.size() > 0);
        chk("sout_valid", sout_valid, exp_act);
        chk("sout", sout, exp_act ? q[0] : 1'b1);
        chk("done", done, exp_act && q.size() == 1 && !h);
        chk("load_ready", load_ready, exp_ready(h));
        if (sout_valid) n_valid++;
        if (sout_valid && !hold) cap.push_back(sout);
        if (done) n_done++;
        @(posedge clk);
        if (lv && exp_ready(h)) begin
            q.delete();
            for (int i = 0; i < W; i++) begin
`ifdef PISO_MSB_FIRST_EN
                q.push_back(ld[W-1-i]);
`else
                q.push_back(ld[i]);
`endif
            end
        end else if (q.size() > 0 && !h) begin
            void'(q.pop_front());
        end
        #1;
    endtask

    initial begin
        rst        = 1'b1;
        load_valid = 1'b0;
        load_data  = '0;
        hold       = 1'b0;
        #1;
        chk("rst_sout", sout, 1'b1);
        chk("rst_sout_valid", sout_valid, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_load_ready", load_ready, 1'b0);
        #10;
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Reset release, then single word 0xC1
        cycle(1'b0, 8'h00, 1'b0);
        clr_stats();
        cycle(1'b1, 8'hC1, 1'b0);
        for (int i = 0; i < W; i++) cycle(1'b0, 8'h00, 1'b0);
        cycle(1'b0, 8'h00, 1'b0);
        chk_int("c1_valid_cycles", n_valid, 8);
        chk_int("c1_done_count", n_done, 1);
        chk_int("c1_bits", cap.size(), 8);
        if (cap.size() >= 8) chk_int("c1_word", word_at(0), 'hC1);

        // Back-to-back 0xC1 then 0x3C; mid-word 0x3C offers must be ignored
        clr_stats();
        cycle(1'b1, 8'hC1, 1'b0);
        for (int i = 0; i < W; i++) cycle(1'b1, 8'h3C, 1'b0);
        for (int i = 0; i < W; i++) cycle(1'b0, 8'h00, 1'b0);
        cycle(1'b0, 8'h00, 1'b0);
        chk_int("b2b_valid_cycles", n_valid, 16);
        chk_int("b2b_done_count", n_done, 2);
        chk_int("b2b_bits", cap.size(), 16);
        if (cap.size() >= 16) begin
            chk_int("b2b_word0", word_at(0), 'hC1);
            chk_int("b2b_word1", word_at(8), 'h3C);
        end

        // Hold for 3 cycles on the 4th bit
        clr_stats();
        cycle(1'b1, 8'hA5, 1'b0);
        for (int i = 0; i < 3; i++) cycle(1'b0, 8'h00, 1'b0);
        for (int i = 0; i < 3; i++) cycle(1'b1, 8'hFF, 1'b1);
        for (int i = 0; i < 5; i++) cycle(1'b0, 8'h00, 1'b0);
        cycle(1'b0, 8'h00, 1'b0);
        chk_int("hold_valid_cycles", n_valid, 11);
        chk_int("hold_done_count", n_done, 1);
        if (cap.size() >= 8) chk_int("hold_word", word_at(0), 'hA5);

        // Asynchronous reset during the 5th bit
        clr_stats();
        cycle(1'b1, 8'h5A, 1'b0);
        for (int i = 0; i < 4; i++) cycle(1'b0, 8'h00, 1'b0);
        #2;
        rst = 1'b1;
        #1;
        chk("arst_sout", sout, 1'b1);
        chk("arst_sout_valid", sout_valid, 1'b0);
        chk("arst_done", done, 1'b0);
        chk("arst_load_ready", load_ready, 1'b0);
        q.delete();
        @(negedge clk);
        #1;
        rst = 1'b0;
        clr_stats();
        for (int i = 0; i < 10; i++) cycle(1'b0, 8'h00, 1'b0);
        chk_int("arst_residual_valid", n_valid, 0);

        // Random traffic against the model
        for (int i = 0; i < 400; i++) begin
            cycle(1'($urandom_range(0, 1)), 8'($urandom), 1'($urandom_range(0, 3) == 0));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
